// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream packet FIFO.
package stream_pkg;

  // Store-and-forward (PF_STORE) or forced cut-through for oversize packets (PF_CUT).
  typedef enum logic {
    PF_STORE = 1'b0,
    PF_CUT   = 1'b1
  } pkt_fifo_state_e;

  // Difference a - b of two wrap-bit pointers that are w bits wide, modulo 2^w.
  function automatic logic [31:0] ptr_diff(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int unsigned w);
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    return (a - b) & mask;
  endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// Entry storage for the packet FIFO: one synchronous write port and one
// asynchronous read port. Contents are not reset; pointers decide validity.
module stream_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write one entry per accepted word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stream_packet_fifo.sv
// Store-and-forward packet FIFO downstream of stream_arbiter.
// Packets become visible only once their last word is stored; a packet that
// fills the whole buffer is escalated to cut-through so the FIFO cannot
// deadlock.
// Optional feature: define STREAM_PKT_FIFO_DROP_EN to add s_drop_i, which
// discards a stored packet when raised with its last word.
//
// Handshake: a word moves on an interface exactly on a rising edge where
// valid and ready are both 1; the sender holds valid and payload stable until
// then, and the FIFO holds m_valid_o and all m_* fields stable until accepted.
module stream_packet_fifo
  import stream_pkg::*;
#(
  parameter  int T_DATA_WIDTH = 8,
  parameter  int T_QOS_WIDTH  = 4,
  parameter  int STREAM_COUNT = 2,
  parameter  int DEPTH        = 16,
  localparam int T_ID_WIDTH   = $clog2(STREAM_COUNT),
  localparam int PTR_W        = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [T_DATA_WIDTH-1:0] s_data_i,
  input  logic [T_QOS_WIDTH-1:0]  s_qos_i,
  input  logic [T_ID_WIDTH-1:0]   s_id_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic [T_QOS_WIDTH-1:0]  m_qos_o,
  output logic [T_ID_WIDTH-1:0]   m_id_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
`ifdef STREAM_PKT_FIFO_DROP_EN
  input  logic                    s_drop_i,
`endif
  output logic [PTR_W:0]          pkt_count_o,
  output logic [PTR_W:0]          level_o,
  output pkt_fifo_state_e         fsm_state_o
);

  localparam int CW      = PTR_W + 1;
  localparam int ENTRY_W = T_DATA_WIDTH + T_QOS_WIDTH + T_ID_WIDTH + 1;

  logic [CW-1:0]      wr_ptr, commit_ptr, rd_ptr, pkt_count, level;
  pkt_fifo_state_e    state;
  logic               full, wr_en, rd_en, m_valid;
  logic               drop_req, drop_last, mem_we;
  logic               commit_last, read_last;
  logic [ENTRY_W-1:0] wr_entry, rd_entry;

`ifdef STREAM_PKT_FIFO_DROP_EN
  assign drop_req = s_drop_i;
`else
  assign drop_req = 1'b0;
`endif

  assign level     = CW'(ptr_diff(32'(wr_ptr), 32'(rd_ptr), CW));
  assign full      = (level == CW'(DEPTH));
  assign s_ready_o = !full && !rst;
  assign wr_en     = s_valid_i && s_ready_o;
  assign m_valid   = (rd_ptr != commit_ptr);
  assign rd_en     = m_valid && m_ready_i;

  // Drop only applies to a last word accepted while storing.
  assign drop_last   = wr_en && s_last_i && drop_req && (state == PF_STORE);
  assign mem_we      = wr_en && !drop_last;
  assign commit_last = wr_en && s_last_i && !drop_last;
  assign read_last   = rd_en && rd_entry[0];

  assign wr_entry = {s_data_i, s_qos_i, s_id_i, s_last_i};

  stream_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .AW    (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr[PTR_W-1:0]),
    .wdata (wr_entry),
    .raddr (rd_ptr[PTR_W-1:0]),
    .rdata (rd_entry)
  );

  // Head entry fields, forced to zero while nothing is committed.
  assign m_valid_o = m_valid;
  assign m_data_o  = m_valid ? rd_entry[ENTRY_W-1 -: T_DATA_WIDTH] : '0;
  assign m_qos_o   = m_valid ? rd_entry[ENTRY_W-T_DATA_WIDTH-1 -: T_QOS_WIDTH] : '0;
  assign m_id_o    = m_valid ? rd_entry[T_ID_WIDTH:1] : '0;
  assign m_last_o  = m_valid ? rd_entry[0] : 1'b0;

  assign pkt_count_o = pkt_count;
  assign level_o     = level;
  assign fsm_state_o = state;

  // Write and read pointers; a dropped packet rewinds the write pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (drop_last)  wr_ptr <= commit_ptr;
      else if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en)      rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Commit FSM: publishes whole packets, or every word while cutting through.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PF_STORE;
      commit_ptr <= '0;
    end else begin
      case (state)
        PF_STORE: begin
          if (commit_last) begin
            commit_ptr <= wr_ptr + 1'b1;
          end else if (full && (commit_ptr == rd_ptr)) begin
            // Buffer holds only part of one packet: release it.
            state      <= PF_CUT;
            commit_ptr <= wr_ptr;
          end
        end
        PF_CUT: begin
          if (wr_en) begin
            commit_ptr <= wr_ptr + 1'b1;
            if (s_last_i) state <= PF_STORE;
          end
        end
        default: state <= PF_STORE;
      endcase
    end
  end

  // Complete-packet counter: up on committed last word, down on read last word.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count <= '0;
    end else begin
      case ({commit_last, read_last})
        2'b10:   pkt_count <= pkt_count + 1'b1;
        2'b01:   pkt_count <= pkt_count - 1'b1;
        default: pkt_count <= pkt_count;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_packet_fifo.sv
// Bench for stream_packet_fifo with DEPTH=4: directed scenarios followed by
// randomized traffic, all checked against a queue-level reference model.
module tb_stream_packet_fifo;
  import stream_pkg::*;

  localparam int DW    = 8;
  localparam int QW    = 4;
  localparam int SC    = 2;
  localparam int DEPTH = 4;
  localparam int IW    = 1;
  localparam int CW    = 3;
  localparam int EW    = DW + QW + IW + 1;
`ifdef STREAM_PKT_FIFO_DROP_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic [DW-1:0] s_data_i;
  logic [QW-1:0] s_qos_i;
  logic [IW-1:0] s_id_i;
  logic          s_last_i;
  logic          s_valid_i;
  logic          s_ready_o;
  logic [DW-1:0] m_data_o;
  logic [QW-1:0] m_qos_o;
  logic [IW-1:0] m_id_o;
  logic          m_last_o;
  logic          m_valid_o;
  logic          m_ready_i;
  logic          s_drop_i;
  logic [CW-1:0] pkt_count_o;
  logic [CW-1:0] level_o;
  pkt_fifo_state_e fsm_state_o;

  int checks   = 0;
  int failures = 0;

  // Reference model: FIFO contents as a queue, split into committed head
  // entries and uncommitted tail entries.
  logic [EW-1:0]      exp_q[$];
  int                 n_commit = 0;
  int                 n_unc    = 0;
  bit                 cut      = 1'b0;
  int                 pkt_cnt  = 0;
  bit                 last_acc = 1'b0;

  // Observed output words {data, id} and other observations.
  logic [DW+IW-1:0]   obs_q[$];
  bit                 saw_cut  = 1'b0;
  int                 max_pkt  = 0;

  stream_packet_fifo #(
    .T_DATA_WIDTH (DW),
    .T_QOS_WIDTH  (QW),
    .STREAM_COUNT (SC),
    .DEPTH        (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_data_i    (s_data_i),
    .s_qos_i     (s_qos_i),
    .s_id_i      (s_id_i),
    .s_last_i    (s_last_i),
    .s_valid_i   (s_valid_i),
    .s_ready_o   (s_ready_o),
    .m_data_o    (m_data_o),
    .m_qos_o     (m_qos_o),
    .m_id_o      (m_id_o),
    .m_last_o    (m_last_o),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
`ifdef STREAM_PKT_FIFO_DROP_EN
    .s_drop_i    (s_drop_i),
`endif
    .pkt_count_o (pkt_count_o),
    .level_o     (level_o),
    .fsm_state_o (fsm_state_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output with the model state for the current cycle.
  task automatic check_outputs();
    logic [EW-1:0] h;
    bit            v;
    h = (exp_q.size() > 0) ? exp_q[0] : '0;
    v = (n_commit > 0);
    chk("s_ready",   32'(s_ready_o),   32'((exp_q.size() != DEPTH) && !rst));
    chk("m_valid",   32'(m_valid_o),   32'(v));
    chk("m_data",    32'(m_data_o),    v ? 32'(h[EW-1 -: DW]) : 32'd0);
    chk("m_qos",     32'(m_qos_o),     v ? 32'(h[EW-DW-1 -: QW]) : 32'd0);
    chk("m_id",      32'(m_id_o),      v ? 32'(h[IW:1]) : 32'd0);
    chk("m_last",    32'(m_last_o),    v ? 32'(h[0]) : 32'd0);
    chk("pkt_count", 32'(pkt_count_o), 32'(pkt_cnt));
    chk("level",     32'(level_o),     32'(exp_q.size()));
    chk("fsm_state", 32'(fsm_state_o), 32'(cut ? PF_CUT : PF_STORE));
    if (fsm_state_o == PF_CUT) saw_cut = 1'b1;
    if (int'(pkt_count_o) > max_pkt) max_pkt = int'(pkt_count_o);
    if (m_valid_o && m_ready_i && !rst) obs_q.push_back({m_data_o, m_id_o});
  endtask

  // Advance the model over one rising edge using the inputs applied this cycle.
  task automatic model_step();
    bit            full, acc, rd, drop;
    int            old_nc;
    logic [EW-1:0] w;
    last_acc = 1'b0;
    if (rst) begin
      exp_q.delete();
      n_commit = 0;
      n_unc    = 0;
      cut      = 1'b0;
      pkt_cnt  = 0;
      return;
    end
    full   = (exp_q.size() == DEPTH);
    acc    = s_valid_i && !full;
    old_nc = n_commit;
    rd     = (old_nc > 0) && m_ready_i;
    drop   = DROP_EN && s_drop_i;
    last_acc = acc;
    if (rd) begin
      w = exp_q.pop_front();
      n_commit--;
      if (w[0]) pkt_cnt--;
    end
    if (!cut) begin
      if (acc && s_last_i && drop) begin
        repeat (n_unc) void'(exp_q.pop_back());
        n_unc = 0;
      end else if (acc && s_last_i) begin
        exp_q.push_back({s_data_i, s_qos_i, s_id_i, s_last_i});
        n_commit += n_unc + 1;
        n_unc    = 0;
        pkt_cnt++;
      end else if (acc) begin
        exp_q.push_back({s_data_i, s_qos_i, s_id_i, s_last_i});
        n_unc++;
      end else if (full && old_nc == 0) begin
        cut      = 1'b1;
        n_commit += n_unc;
        n_unc    = 0;
      end
    end else if (acc) begin
      exp_q.push_back({s_data_i, s_qos_i, s_id_i, s_last_i});
      n_commit += n_unc + 1;
      n_unc    = 0;
      if (s_last_i) begin
        pkt_cnt++;
        cut = 1'b0;
      end
    end
  endtask

  // Driver: one cycle, starting and ending just after a falling edge.
  task automatic cycle(input bit v, input logic [DW-1:0] d, input logic [QW-1:0] q,
                       input logic [IW-1:0] id, input bit l, input bit dr,
                       input bit mr, input bit r);
    s_valid_i = v;
    s_data_i  = d;
    s_qos_i   = q;
    s_id_i    = id;
    s_last_i  = l;
    s_drop_i  = dr;
    m_ready_i = mr;
    rst       = r;
    #1 check_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // Present one word until the FIFO takes it (bounded).
  task automatic send_word(input logic [DW-1:0] d, input logic [QW-1:0] q,
                           input logic [IW-1:0] id, input bit l, input bit dr,
                           input bit mr);
    int n;
    n = 0;
    do begin
      cycle(1'b1, d, q, id, l, dr, mr, 1'b0);
      n++;
    end while (!last_acc && n < 40);
    chk("send_word_accepted", 32'(last_acc), 32'd1);
  endtask

  task automatic idle(input int n, input bit mr);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, mr, 1'b0);
  endtask

  task automatic chk_obs(input string tag, input int idx, input logic [DW+IW-1:0] exp);
    chk(tag, (idx < obs_q.size()) ? 32'(obs_q[idx]) : 32'hDEAD, 32'(exp));
  endtask

  initial begin
    int          len, idx;
    logic [DW-1:0] d;
    logic [QW-1:0] q;
    logic [IW-1:0] id;
    bit          v, mr, r, dr;

    s_valid_i = 1'b0; s_data_i = '0; s_qos_i = '0; s_id_i = '0;
    s_last_i = 1'b0; s_drop_i = 1'b0; m_ready_i = 1'b0; rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state, checked while reset is held and on the first cycle after.
    cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1, 1'b1);

    // Scenario 1: 3-word packet, stored then forwarded back to back.
    obs_q.delete();
    send_word(8'h11, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    send_word(8'h22, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    send_word(8'h33, 4'd5, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(5, 1'b1);
    chk("s1_count", obs_q.size(), 32'd3);
    chk_obs("s1_w0", 0, {8'h11, 1'b1});
    chk_obs("s1_w1", 1, {8'h22, 1'b1});
    chk_obs("s1_w2", 2, {8'h33, 1'b1});

    // Scenario 2: two 2-word packets fill the buffer, then drain.
    obs_q.delete();
    send_word(8'hA1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word(8'hA2, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    send_word(8'hB1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    send_word(8'hB2, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    chk("s2_level_full", 32'(level_o), 32'd4);
    chk("s2_ready_low",  32'(s_ready_o), 32'd0);
    chk("s2_pkt_count",  32'(pkt_count_o), 32'd2);
    idle(6, 1'b1);
    chk("s2_count", obs_q.size(), 32'd4);
    chk_obs("s2_w0", 0, {8'hA1, 1'b0});
    chk_obs("s2_w1", 1, {8'hA2, 1'b0});
    chk_obs("s2_w2", 2, {8'hB1, 1'b1});
    chk_obs("s2_w3", 3, {8'hB2, 1'b1});

    // Scenario 3: 6-word packet forces cut-through.
    obs_q.delete();
    saw_cut = 1'b0;
    for (int i = 0; i < 6; i++)
      send_word(8'h61 + 8'(i), 4'd3, 1'b0, (i == 5), 1'b0, 1'b1);
    idle(5, 1'b1);
    chk("s3_cut_seen", 32'(saw_cut), 32'd1);
    chk("s3_state_back", 32'(fsm_state_o), 32'(PF_STORE));
    chk("s3_count", obs_q.size(), 32'd6);
    for (int i = 0; i < 6; i++) chk_obs("s3_word", i, {8'h61 + 8'(i), 1'b0});

    // Scenario 4: reset mid-packet, then a 1-word packet.
    obs_q.delete();
    send_word(8'h71, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1);
    send_word(8'h72, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    chk("s4_level_cleared", 32'(level_o), 32'd0);
    chk("s4_valid_cleared", 32'(m_valid_o), 32'd0);
    send_word(8'h81, 4'd7, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(3, 1'b1);
    chk("s4_count", obs_q.size(), 32'd1);
    chk_obs("s4_w0", 0, {8'h81, 1'b0});

    // Scenario 5: downstream ready toggling during output.
    obs_q.delete();
    send_word(8'h91, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    send_word(8'h92, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    send_word(8'h93, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1, 1'b0);
    for (int i = 0; i < 8; i++) idle(1, (i % 2) == 0);
    chk("s5_count", obs_q.size(), 32'd3);
    chk_obs("s5_w0", 0, {8'h91, 1'b1});
    chk_obs("s5_w1", 1, {8'h92, 1'b1});
    chk_obs("s5_w2", 2, {8'h93, 1'b1});

`ifdef STREAM_PKT_FIFO_DROP_EN
    // Scenario 6: dropped packet followed by a kept one.
    obs_q.delete();
    max_pkt = 0;
    send_word(8'hD1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    send_word(8'hD2, 4'd1, 1'b0, 1'b1, 1'b1, 1'b1);
    send_word(8'h44, 4'd1, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(3, 1'b1);
    chk("s6_count", obs_q.size(), 32'd1);
    chk_obs("s6_w0", 0, {8'h44, 1'b1});
    chk("s6_pkt_peak", 32'(max_pkt), 32'd1);
`endif

    // Randomized traffic with occasional resets.
    len = $urandom_range(1, 6);
    idx = 0;
    d   = 8'($urandom);
    q   = 4'($urandom);
    id  = 1'($urandom);
    for (int c = 0; c < 500; c++) begin
      v  = ($urandom_range(0, 3) != 0);
      mr = ($urandom_range(0, 2) != 0);
      r  = ($urandom_range(0, 149) == 0);
      dr = ($urandom_range(0, 3) == 0);
      cycle(v, d, q, id, (idx == len - 1), dr, mr, r);
      if (r) begin
        idx = 0;
      end else if (last_acc) begin
        idx++;
        d = 8'($urandom);
      end
      if (r || idx == len) begin
        idx = 0;
        len = $urandom_range(1, 6);
        q   = 4'($urandom);
        id  = 1'($urandom);
      end
    end
    idle(10, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
